riscv_irq_arbiter: RTL and testbench



---
 rtl/riscv_defines.sv | 22 ++
 rtl/riscv_irq_arbiter_if.sv | 31 +++
 rtl/riscv_irq_prio_sel.sv | 46 ++++
 rtl/riscv_irq_arbiter.sv | 126 ++++++++++++
 tb/tb_riscv_irq_arbiter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_defines.sv
// Shared definitions for the interrupt arbiter: id width, FSM state enum, pointer helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package riscv_defines;

  localparam int IRQ_ID_W = 5;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_REQ  = 1'b1
  } irq_arb_state_t;

  // Next round-robin start point: one past the granted id, wrapping at the line count.
  function automatic logic [IRQ_ID_W-1:0] irq_id_inc_wrap(input logic [IRQ_ID_W-1:0] id,
                                                         input int num_lines);
    if (int'(id) >= num_lines - 1) begin
      return '0;
    end
    return id + 1'b1;
  endfunction

endpackage

// File: rtl/riscv_irq_arbiter_if.sv
// Bundle of platform lines, CSR mask and core-side request/ack for the interrupt arbiter.
// Latency: none (wiring only).
// Backpressure: the core holds off by not pulsing irq_ack_i; the request stays presented.
interface riscv_irq_arbiter_if
  import riscv_defines::*;
#(
  parameter int NUM_LINES = 32
);

  logic [NUM_LINES-1:0] irq_lines_i;
  logic [NUM_LINES-1:0] irq_sec_lines_i;
  logic [NUM_LINES-1:0] irq_en_i;
  logic                 irq_ack_i;
  logic                 irq_o;
  logic [IRQ_ID_W-1:0]  irq_id_o;
  logic                 irq_sec_o;
  logic [NUM_LINES-1:0] pending_o;

  // Platform / core / CSR side: drives lines, mask and ack, observes the request.
  modport master (
    output irq_lines_i, irq_sec_lines_i, irq_en_i, irq_ack_i,
    input  irq_o, irq_id_o, irq_sec_o, pending_o
  );

  // Arbiter side.
  modport slave (
    input  irq_lines_i, irq_sec_lines_i, irq_en_i, irq_ack_i,
    output irq_o, irq_id_o, irq_sec_o, pending_o
  );

endinterface

// File: rtl/riscv_irq_prio_sel.sv
// Find-first-set over req_i starting at start_i, wrapping past the top index to 0.
// Latency: purely combinational.
// Backpressure: none; valid_o is low when no request bit is set.
module riscv_irq_prio_sel
  import riscv_defines::*;
#(
  parameter int NUM_LINES = 32
) (
  input  logic [NUM_LINES-1:0] req_i,
  input  logic [IRQ_ID_W-1:0]  start_i,
  output logic                 valid_o,
  output logic [IRQ_ID_W-1:0]  id_o
);

  logic [NUM_LINES-1:0] upper_req;
  logic                 upper_vld;
  logic [IRQ_ID_W-1:0]  upper_id;
  logic                 any_vld;
  logic [IRQ_ID_W-1:0]  any_id;

  // Split the search: requests at/above the start point win; otherwise wrap to the lowest set bit.
  always_comb begin
    upper_req = '0;
    upper_vld = 1'b0;
    upper_id  = '0;
    any_vld   = 1'b0;
    any_id    = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      upper_req[i] = req_i[i] & (IRQ_ID_W'(i) >= start_i);
    end
    // Descending scan so the lowest qualifying index is the last one written.
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (upper_req[i]) begin
        upper_vld = 1'b1;
        upper_id  = IRQ_ID_W'(i);
      end
      if (req_i[i]) begin
        any_vld = 1'b1;
        any_id  = IRQ_ID_W'(i);
      end
    end
    valid_o = upper_vld | any_vld;
    id_o    = upper_vld ? upper_id : any_id;
  end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// Edge-detects interrupt lines into a pending register and presents one winner to the core as a level request.
// Latency: edge at clock N -> pending after N, irq_o after N+1; one idle cycle minimum between requests.
// Backpressure: request holds until irq_ack_i; withdrawn if its enable drops. RISCV_IRQ_ARB_RR_EN selects round-robin.
module riscv_irq_arbiter
  import riscv_defines::*;
#(
  parameter int NUM_LINES = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  riscv_irq_arbiter_if.slave bus
);

  logic [NUM_LINES-1:0] prev_q;
  logic [NUM_LINES-1:0] pending_q;
  logic [NUM_LINES-1:0] pending_d;
  logic [NUM_LINES-1:0] rise;
  logic [NUM_LINES-1:0] eligible;
  logic [NUM_LINES-1:0] clr_mask;
  irq_arb_state_t       state_q;
  irq_arb_state_t       state_d;
  logic [IRQ_ID_W-1:0]  id_q;
  logic [IRQ_ID_W-1:0]  id_d;
  logic                 sec_q;
  logic                 sec_d;
  logic                 ack_clr;
  logic                 sel_vld;
  logic [IRQ_ID_W-1:0]  sel_id;
  logic [IRQ_ID_W-1:0]  sel_start;

  assign rise     = bus.irq_lines_i & ~prev_q;
  assign eligible = pending_q & bus.irq_en_i;

  riscv_irq_prio_sel #(
    .NUM_LINES (NUM_LINES)
  ) u_prio_sel (
    .req_i   (eligible),
    .start_i (sel_start),
    .valid_o (sel_vld),
    .id_o    (sel_id)
  );

`ifdef RISCV_IRQ_ARB_RR_EN
  logic [IRQ_ID_W-1:0] rr_q;
  logic [IRQ_ID_W-1:0] rr_d;

  // Advance the search start past each granted id so every eligible line gets a turn.
  always_comb begin
    rr_d = rr_q;
    if ((state_q == ARB_IDLE) && sel_vld) begin
      rr_d = irq_id_inc_wrap(sel_id, NUM_LINES);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign sel_start = rr_q;
`else
  assign sel_start = '0;
`endif

  // Arbitration FSM: grant only from IDLE, hold the presented id until ack or withdraw.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    sec_d   = sec_q;
    ack_clr = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (sel_vld) begin
          id_d    = sel_id;
          sec_d   = bus.irq_sec_lines_i[sel_id];
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (bus.irq_ack_i) begin
          ack_clr = 1'b1;
          state_d = ARB_IDLE;
        end else if (!bus.irq_en_i[id_q]) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Retire the acknowledged bit; a fresh edge in the same cycle re-sets it (set wins).
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      clr_mask[i] = ack_clr & (id_q == IRQ_ID_W'(i));
    end
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  // State, presented request and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
      state_q   <= ARB_IDLE;
      id_q      <= '0;
      sec_q     <= 1'b0;
    end else begin
      prev_q    <= bus.irq_lines_i;
      pending_q <= pending_d;
      state_q   <= state_d;
      id_q      <= id_d;
      sec_q     <= sec_d;
    end
  end

  assign bus.irq_o     = (state_q == ARB_REQ);
  assign bus.irq_id_o  = id_q;
  assign bus.irq_sec_o = sec_q;
  assign bus.pending_o = pending_q;

endmodule

// File: tb/tb_riscv_irq_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: ack is driven randomly to exercise holding, withdraw and retire.
module tb_riscv_irq_arbiter;

  localparam int N = 32;

  logic clk;
  logic rst_n;

  riscv_irq_arbiter_if #(.NUM_LINES(N)) bus ();

  riscv_irq_arbiter #(.NUM_LINES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  logic [N-1:0] m_pend;
  logic [N-1:0] m_prev;
  bit           m_req;
  int           m_id;
  bit           m_sec;
  int           m_rr;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // First eligible index walking upward from start, wrapping modulo N; -1 if none.
  function automatic int pick(input logic [N-1:0] el, input int start);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (start + k) % N;
      if (el[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_prev = '0;
    m_req  = 0;
    m_id   = 0;
    m_sec  = 0;
    m_rr   = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".irq"}, 32'(bus.irq_o), 32'(m_req));
    check_eq({tag, ".id"}, 32'(bus.irq_id_o), 32'(m_id));
    check_eq({tag, ".sec"}, 32'(bus.irq_sec_o), 32'(m_sec));
    check_eq({tag, ".pend"}, 32'(bus.pending_o), 32'(m_pend));
  endtask

  // One clock: predict from the inputs currently driven, step, then compare.
  task automatic cycle();
    logic [N-1:0] lines, en, sec, np;
    bit ack, nreq, nsec;
    int nid, nrr, w, start;
    lines = bus.irq_lines_i;
    en    = bus.irq_en_i;
    sec   = bus.irq_sec_lines_i;
    ack   = bus.irq_ack_i;
    np    = m_pend;
    nreq  = m_req;
    nid   = m_id;
    nsec  = m_sec;
    nrr   = m_rr;
    if (m_req) begin
      if (ack) begin
        np[m_id] = 1'b0;
        nreq = 0;
      end else if (!en[m_id]) begin
        nreq = 0;
      end
    end else begin
`ifdef RISCV_IRQ_ARB_RR_EN
      start = m_rr;
`else
      start = 0;
`endif
      w = pick(m_pend & en, start);
      if (w >= 0) begin
        nreq = 1;
        nid  = w;
        nsec = sec[w];
        nrr  = (w + 1) % N;
      end
    end
    np = np | (lines & ~m_prev);
    @(posedge clk);
    #1;
    m_pend = np;
    m_prev = lines;
    m_req  = nreq;
    m_id   = nid;
    m_sec  = nsec;
    m_rr   = nrr;
    check_all("cyc");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    #1;
    rst_n = 1'b1;
  endtask

  task automatic wait_irq(input int bound);
    for (int i = 0; i < bound && !bus.irq_o; i++) cycle();
    check_eq("irq_wait", 32'(bus.irq_o), 32'd1);
  endtask

  int exp_id;

  initial begin
    rst_n               = 1'b0;
    bus.irq_lines_i     = '0;
    bus.irq_sec_lines_i = 32'hA5A5_0F0F;
    bus.irq_en_i        = '1;
    bus.irq_ack_i       = 1'b0;
    model_reset();
    @(posedge clk);
    #1;

    // Line 3 already high at reset release counts as an edge.
    bus.irq_lines_i = 32'h8;
    do_reset();
    cycle();
    check_eq("l3.pend", 32'(bus.pending_o), 32'h8);
    check_eq("l3.noirq", 32'(bus.irq_o), 32'd0);
    cycle();
    check_eq("l3.irq", 32'(bus.irq_o), 32'd1);
    check_eq("l3.id", 32'(bus.irq_id_o), 32'd3);
    bus.irq_ack_i = 1'b1;
    cycle();
    bus.irq_ack_i = 1'b0;
    check_eq("l3.ackpend", 32'(bus.pending_o), 32'h0);
    check_eq("l3.ackirq", 32'(bus.irq_o), 32'd0);
    bus.irq_lines_i = '0;

    // Lines 5 and 9 together: 5 first, 9 after one idle cycle.
    do_reset();
    bus.irq_lines_i = (32'h1 << 5) | (32'h1 << 9);
    cycle();
    bus.irq_lines_i = '0;
    cycle();
    check_eq("p59.first", 32'(bus.irq_id_o), 32'd5);
    bus.irq_ack_i = 1'b1;
    cycle();
    bus.irq_ack_i = 1'b0;
    check_eq("p59.gap", 32'(bus.irq_o), 32'd0);
    cycle();
    check_eq("p59.irq2", 32'(bus.irq_o), 32'd1);
    check_eq("p59.second", 32'(bus.irq_id_o), 32'd9);
    bus.irq_ack_i = 1'b1;
    cycle();
    bus.irq_ack_i = 1'b0;

    // Four rounds, both lines re-pulsed in each ack cycle.
    bus.irq_lines_i = (32'h1 << 5) | (32'h1 << 9);
    cycle();
    bus.irq_lines_i = '0;
    for (int r = 0; r < 4; r++) begin
      wait_irq(8);
`ifdef RISCV_IRQ_ARB_RR_EN
      exp_id = (r % 2 == 0) ? 5 : 9;
`else
      exp_id = 5;
`endif
      check_eq("rounds.id", 32'(bus.irq_id_o), 32'(exp_id));
      bus.irq_ack_i   = 1'b1;
      bus.irq_lines_i = (32'h1 << 5) | (32'h1 << 9);
      cycle();
      bus.irq_ack_i   = 1'b0;
      bus.irq_lines_i = '0;
      cycle();
    end

    // Masked line 7, then enable, then withdraw in REQ.
    do_reset();
    bus.irq_en_i    = ~(32'h1 << 7);
    bus.irq_lines_i = 32'h1 << 7;
    cycle();
    bus.irq_lines_i = '0;
    for (int i = 0; i < 3; i++) cycle();
    check_eq("l7.masked", 32'(bus.irq_o), 32'd0);
    bus.irq_en_i = '1;
    cycle();
    check_eq("l7.irq", 32'(bus.irq_o), 32'd1);
    check_eq("l7.id", 32'(bus.irq_id_o), 32'd7);
    bus.irq_en_i = ~(32'h1 << 7);
    cycle();
    check_eq("l7.withdraw", 32'(bus.irq_o), 32'd0);
    check_eq("l7.kept", 32'(bus.pending_o[7]), 32'd1);
    bus.irq_en_i = '1;
    wait_irq(4);
    bus.irq_ack_i = 1'b1;
    cycle();
    bus.irq_ack_i = 1'b0;

    // Line 2 rises again in its own ack cycle.
    do_reset();
    bus.irq_lines_i = 32'h4;
    cycle();
    bus.irq_lines_i = '0;
    cycle();
    check_eq("l2.id", 32'(bus.irq_id_o), 32'd2);
    bus.irq_ack_i   = 1'b1;
    bus.irq_lines_i = 32'h4;
    cycle();
    bus.irq_ack_i   = 1'b0;
    bus.irq_lines_i = '0;
    check_eq("l2.setwins", 32'(bus.pending_o[2]), 32'd1);
    check_eq("l2.gap", 32'(bus.irq_o), 32'd0);
    cycle();
    check_eq("l2.again", 32'(bus.irq_o), 32'd1);
    check_eq("l2.again_id", 32'(bus.irq_id_o), 32'd2);
    bus.irq_ack_i = 1'b1;
    cycle();
    bus.irq_ack_i = 1'b0;

    // Spurious ack in IDLE, then asynchronous reset during REQ.
    do_reset();
    bus.irq_en_i    = '0;
    bus.irq_lines_i = 32'h10;
    cycle();
    bus.irq_lines_i = '0;
    bus.irq_ack_i   = 1'b1;
    cycle();
    bus.irq_ack_i   = 1'b0;
    check_eq("spur.pend", 32'(bus.pending_o), 32'h10);
    check_eq("spur.irq", 32'(bus.irq_o), 32'd0);
    bus.irq_en_i = '1;
    cycle();
    check_eq("arst.pre", 32'(bus.irq_o), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.irq", 32'(bus.irq_o), 32'd0);
    check_eq("arst.id", 32'(bus.irq_id_o), 32'd0);
    check_eq("arst.sec", 32'(bus.irq_sec_o), 32'd0);
    check_eq("arst.pend", 32'(bus.pending_o), 32'd0);
    model_reset();
    rst_n = 1'b1;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      bus.irq_lines_i     = bus.irq_lines_i ^ ($urandom & $urandom & $urandom);
      bus.irq_sec_lines_i = $urandom;
      if ($urandom_range(0, 15) == 0) bus.irq_en_i = ~($urandom & $urandom);
      if (bus.irq_o) bus.irq_ack_i = ($urandom_range(0, 2) == 0);
      else           bus.irq_ack_i = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
